// File: rtl/score_pkg.sv
// Shared op encodings and address-width helper for the score bank.
package score_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_LOAD = 2'b10,
      OP_NOP  = 2'b11
   } op_e;

   // A one-channel bank still needs a 1-bit address port.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sat_addsub.sv
// Combinational saturating add / floored subtract / load for one score value.
module sat_addsub
   import score_pkg::*;
#(
   parameter int W     = 8,
   parameter int INC_W = 5
) (
   input  logic [W-1:0]     s,
   input  logic [INC_W-1:0] d,
   input  logic [1:0]       op,
   output logic [W-1:0]     s_next,
   output logic             clipped
);

   localparam logic [W:0] MAX_VAL = {1'b0, {W{1'b1}}};

   logic [W:0] d_ext;
   logic [W:0] sum;
   logic [W:0] diff;

   // One guard bit above the score makes overflow and borrow directly visible.
   assign d_ext = {{(W + 1 - INC_W){1'b0}}, d};
   assign sum   = {1'b0, s} + d_ext;
   assign diff  = {1'b0, s} - d_ext;

   always_comb begin
      s_next  = s;
      clipped = 1'b0;
      case (op)
         OP_ADD: begin
            if (sum > MAX_VAL) begin
               s_next  = {W{1'b1}};
               clipped = 1'b1;
            end else begin
               s_next = sum[W-1:0];
            end
         end
         OP_SUB: begin
            if (diff[W]) begin
               s_next  = '0;
               clipped = 1'b1;
            end else begin
               s_next = diff[W-1:0];
            end
         end
         OP_LOAD: s_next = d_ext[W-1:0];
         default: s_next = s;
      endcase
   end

endmodule

// File: rtl/score_bank.sv
// Bank of per-player saturating score accumulators with sticky saturation
// flags and a registered leader (max score, lowest index on ties).
module score_bank
   import score_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int W        = 8,
   parameter int INC_W    = 5,
   parameter int ZERO_CH0 = 1,
   localparam int ADDR_W  = addr_w(NUM_CH)
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              write,
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [INC_W-1:0]  wr_data,
   input  logic              clear,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [W-1:0]      rd_data,
   output logic [NUM_CH-1:0] sat,
   output logic [ADDR_W-1:0] leader_idx,
   output logic [W-1:0]      leader_score,
   output logic              leader_valid
);

   logic [W-1:0]      score [NUM_CH];
   logic [W-1:0]      cur_score;
   logic [W-1:0]      new_score;
   logic              new_clipped;
   logic [W-1:0]      best_score;
   logic [ADDR_W-1:0] best_idx;
   logic [ADDR_W-1:0] leader_idx_reg;
   logic [W-1:0]      leader_score_reg;
   logic              leader_valid_reg;

   // Single write port: select the addressed score; out-of-range reads as 0.
   always_comb begin
      cur_score = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (wr_addr == ADDR_W'(i)) cur_score = score[i];
      end
   end

   sat_addsub #(
      .W     (W),
      .INC_W (INC_W)
   ) u_addsub (
      .s       (cur_score),
      .d       (wr_data),
      .op      (op),
      .s_next  (new_score),
      .clipped (new_clipped)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         if (ZERO_CH0 != 0 && gi == 0) begin : g_zero
            assign score[gi] = '0;
            assign sat[gi]   = 1'b0;
         end else begin : g_live
            logic         wr_hit;
            logic         clr_hit;
            logic [W-1:0] score_reg;
            logic         sat_reg;

            assign wr_hit  = write && (wr_addr == ADDR_W'(gi));
            assign clr_hit = clear && (clr_addr == ADDR_W'(gi));

            // Clear beats a same-cycle write to the same channel.
            always_ff @(posedge clock or negedge rst_n) begin
               if (!rst_n) begin
                  score_reg <= '0;
                  sat_reg   <= 1'b0;
               end else if (clr_hit) begin
                  score_reg <= '0;
                  sat_reg   <= 1'b0;
               end else if (wr_hit) begin
                  score_reg <= new_score;
                  if (new_clipped) sat_reg <= 1'b1;
               end
            end

            assign score[gi] = score_reg;
            assign sat[gi]   = sat_reg;
         end
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_addr == ADDR_W'(i)) rd_data = score[i];
      end
   end

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      best_score = score[0];
      best_idx   = '0;
      for (int i = 1; i < NUM_CH; i++) begin
         if (score[i] > best_score) begin
            best_score = score[i];
            best_idx   = ADDR_W'(i);
         end
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         leader_idx_reg   <= '0;
         leader_score_reg <= '0;
         leader_valid_reg <= 1'b0;
      end else begin
         leader_idx_reg   <= best_idx;
         leader_score_reg <= best_score;
         leader_valid_reg <= (best_score != '0);
      end
   end

   assign leader_idx   = leader_idx_reg;
   assign leader_score = leader_score_reg;
   assign leader_valid = leader_valid_reg;

endmodule
